mips_fetch_exec_unit: RTL and testbench

//  Single-cycle MIPS core slice: program counter, next-PC logic, main/ALU decoder and 32-bit ALU.

---
 rtl/mips_fetch_exec_unit.sv | 173 +++++++++++++++++
 tb/tb_mips_fetch_exec_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_exec_unit.sv
// Single-cycle MIPS fetch/execute slice: program counter, next-PC selection,
// main/ALU decode and the 32-bit ALU, with a sticky halt raised by syscall.
module mips_fetch_exec_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] inst_addr,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_write_en,
  output logic        halted
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ   = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                         OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
                         OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_JR   = 6'h08, FN_SYSC = 6'h0C, FN_ADD  = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] pc_q, pc_next, pc4;
  logic [31:0] imm_sext, imm_zext, src_b;
  logic        halted_q;

  alu_op_e alu_op;
  logic    use_imm, imm_unsigned;
  logic    is_beq, is_bne, is_j, is_jr, is_syscall;
  logic    dec_reg_write, dec_mem_write;

  assign opcode   = inst[31:26];
  assign funct    = inst[5:0];
  assign shamt    = inst[10:6];
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'h0000, inst[15:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    alu_op        = ALU_ADD;
    use_imm       = 1'b0;
    imm_unsigned  = 1'b0;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    is_j          = 1'b0;
    is_jr         = 1'b0;
    is_syscall    = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_write = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        reg_dst       = 1'b1;
        dec_reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_JR: begin
            is_jr         = 1'b1;
            dec_reg_write = 1'b0;
          end
          FN_SYSC: begin
            is_syscall    = 1'b1;
            dec_reg_write = 1'b0;
          end
          default: begin
            reg_dst       = 1'b0;
            dec_reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; dec_reg_write = 1'b1; alu_op = ALU_ADD;  end
      OP_SLTI:           begin use_imm = 1'b1; dec_reg_write = 1'b1; alu_op = ALU_SLT;  end
      OP_SLTIU:          begin use_imm = 1'b1; dec_reg_write = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI: begin use_imm = 1'b1; imm_unsigned = 1'b1; dec_reg_write = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin use_imm = 1'b1; imm_unsigned = 1'b1; dec_reg_write = 1'b1; alu_op = ALU_OR;  end
      OP_XORI: begin use_imm = 1'b1; imm_unsigned = 1'b1; dec_reg_write = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:  begin use_imm = 1'b1; dec_reg_write = 1'b1; alu_op = ALU_LUI; end
      OP_LW: begin
        use_imm       = 1'b1;
        mem_to_reg    = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_SW: begin
        use_imm       = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin is_beq = 1'b1; alu_op = ALU_SUB; end
      OP_BNE: begin is_bne = 1'b1; alu_op = ALU_SUB; end
      OP_J:   is_j = 1'b1;
      default: ;
    endcase
  end

  assign src_b = use_imm ? (imm_unsigned ? imm_zext : imm_sext) : rt_data;

  always_comb begin
    alu_result = 32'h0000_0000;
    case (alu_op)
      ALU_ADD:  alu_result = rs_data + src_b;
      ALU_SUB:  alu_result = rs_data - src_b;
      ALU_AND:  alu_result = rs_data & src_b;
      ALU_OR:   alu_result = rs_data | src_b;
      ALU_XOR:  alu_result = rs_data ^ src_b;
      ALU_NOR:  alu_result = ~(rs_data | src_b);
      ALU_SLT:  alu_result = {31'h0, $signed(rs_data) < $signed(src_b)};
      ALU_SLTU: alu_result = {31'h0, rs_data < src_b};
      ALU_SLL:  alu_result = rt_data << shamt;
      ALU_SRL:  alu_result = rt_data >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(rt_data) >>> shamt);
      ALU_LUI:  alu_result = {inst[15:0], 16'h0000};
      default:  alu_result = 32'h0000_0000;
    endcase
  end

  assign zero = (alu_result == 32'h0000_0000);

  // A halted core (or the syscall instruction itself) freezes the PC and suppresses all writes.
  always_comb begin
    pc4 = pc_q + 32'd4;
    if (halted_q || is_syscall)      pc_next = pc_q;
    else if (is_jr)                  pc_next = rs_data;
    else if (is_j)                   pc_next = {pc4[31:28], inst[25:0], 2'b00};
    else if ((is_beq && zero) || (is_bne && !zero))
                                     pc_next = pc4 + {imm_sext[29:0], 2'b00};
    else                             pc_next = pc4;
  end

  assign reg_write    = dec_reg_write && !halted_q;
  assign mem_write_en = dec_mem_write && !halted_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (is_syscall) halted_q <= 1'b1;
    end
  end

  assign inst_addr = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mips_fetch_exec_unit.sv
// Directed bench for mips_fetch_exec_unit: a table of combinational decode/ALU
// vectors plus hand-written PC, branch, jump and halt sequences.
module tb_mips_fetch_exec_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] inst, rs_data, rt_data;
  logic [31:0] inst_addr, alu_result;
  logic        zero, reg_dst, mem_to_reg, reg_write, mem_write_en, halted;

  int n_checks = 0;
  int n_pass   = 0;

  mips_fetch_exec_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_b(rst_b), .inst(inst), .rs_data(rs_data), .rt_data(rt_data),
    .inst_addr(inst_addr), .alu_result(alu_result), .zero(zero), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_write_en(mem_write_en),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst, rs, rt, alu;
    logic        chk_alu, zero, reg_dst, mem_to_reg, reg_write, mem_write;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic [31:0] i, rs, rt, alu,
                         input logic chk, z, rd, m2r, rw, mw);
    vec_t v;
    v.name = name; v.inst = i; v.rs = rs; v.rt = rt; v.alu = alu;
    v.chk_alu = chk; v.zero = z; v.reg_dst = rd; v.mem_to_reg = m2r;
    v.reg_write = rw; v.mem_write = mw;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] ADDI5 = 32'h2001_0005;

  initial begin
    //       name      inst          rs            rt            alu          chk z rd m2r rw mw
    add_vec("addi",  ADDI5,         32'h0,        32'h0,        32'h5,        1, 0, 0, 0, 1, 0);
    add_vec("sw",    32'hAC22_0004, 32'h100,      32'h0,        32'h104,      1, 0, 0, 0, 0, 1);
    add_vec("lw",    32'h8C22_0004, 32'h100,      32'h0,        32'h104,      1, 0, 0, 1, 1, 0);
    add_vec("slt",   32'h0022_182A, 32'hFFFF_FFFF,32'h1,        32'h1,        1, 0, 1, 0, 1, 0);
    add_vec("sltu",  32'h0022_182B, 32'hFFFF_FFFF,32'h1,        32'h0,        1, 1, 1, 0, 1, 0);
    add_vec("add",   32'h0022_1820, 32'hFFFF_FFFF,32'h1,        32'h0,        1, 1, 1, 0, 1, 0);
    add_vec("sra4",  32'h0022_1903, 32'h0,        32'h8000_0000,32'hF800_0000,1, 0, 1, 0, 1, 0);
    add_vec("srl4",  32'h0022_1902, 32'h0,        32'h8000_0000,32'h0800_0000,1, 0, 1, 0, 1, 0);
    add_vec("sll4",  32'h0022_1900, 32'h0,        32'h1,        32'h10,       1, 0, 1, 0, 1, 0);
    add_vec("sub",   32'h0022_1822, 32'd10,       32'd3,        32'd7,        1, 0, 1, 0, 1, 0);
    add_vec("and",   32'h0022_1824, 32'hF0F0,     32'hFF00,     32'hF000,     1, 0, 1, 0, 1, 0);
    add_vec("or",    32'h0022_1825, 32'hF0F0,     32'hFF00,     32'hFFF0,     1, 0, 1, 0, 1, 0);
    add_vec("xor",   32'h0022_1826, 32'hF0F0,     32'hFF00,     32'h0FF0,     1, 0, 1, 0, 1, 0);
    add_vec("nor",   32'h0022_1827, 32'h0,        32'h0,        32'hFFFF_FFFF,1, 0, 1, 0, 1, 0);
    add_vec("lui",   32'h3C01_1234, 32'hDEAD,     32'h0,        32'h1234_0000,1, 0, 0, 0, 1, 0);
    add_vec("andi",  32'h3021_FFFF, 32'hFFFF_1234,32'h0,        32'h1234,     1, 0, 0, 0, 1, 0);
    add_vec("ori",   32'h3421_F000, 32'hF,        32'h0,        32'hF00F,     1, 0, 0, 0, 1, 0);
    add_vec("xori",  32'h3821_FFFF, 32'hFFFF_FFFF,32'h0,        32'hFFFF_0000,1, 0, 0, 0, 1, 0);
    add_vec("slti",  32'h2821_FFFF, 32'hFFFF_FFFE,32'h0,        32'h1,        1, 0, 0, 0, 1, 0);
    add_vec("sltiu", 32'h2C21_FFFF, 32'h0001_0000,32'h0,        32'h1,        1, 0, 0, 0, 1, 0);
    add_vec("addiu", 32'h2421_FFFF, 32'h1,        32'h0,        32'h0,        1, 1, 0, 0, 1, 0);
    add_vec("beq_alu",32'h1022_0003,32'd9,        32'd7,        32'd2,        1, 0, 0, 0, 0, 0);
    add_vec("bad_op",32'hFC00_0000, 32'h5,        32'h6,        32'h0,        0, 0, 0, 0, 0, 0);
    add_vec("bad_fn",32'h0022_1801, 32'h5,        32'h6,        32'h0,        0, 0, 0, 0, 0, 0);

    // Reset and the addi walk
    rst_b = 1'b1; inst = ADDI5; rs_data = 32'h0; rt_data = 32'h0;
    tick(); tick();
    check("reset_pc", inst_addr, 32'h0);
    check("reset_halted", {31'h0, halted}, 32'h0);

    // Combinational vectors applied while reset holds the PC
    foreach (vecs[i]) begin
      inst = vecs[i].inst; rs_data = vecs[i].rs; rt_data = vecs[i].rt;
      #2;
      if (vecs[i].chk_alu) begin
        check({vecs[i].name, ".alu"},  alu_result, vecs[i].alu);
        check({vecs[i].name, ".zero"}, {31'h0, zero}, {31'h0, vecs[i].zero});
      end
      check({vecs[i].name, ".reg_dst"},    {31'h0, reg_dst},      {31'h0, vecs[i].reg_dst});
      check({vecs[i].name, ".mem_to_reg"}, {31'h0, mem_to_reg},   {31'h0, vecs[i].mem_to_reg});
      check({vecs[i].name, ".reg_write"},  {31'h0, reg_write},    {31'h0, vecs[i].reg_write});
      check({vecs[i].name, ".mem_write"},  {31'h0, mem_write_en}, {31'h0, vecs[i].mem_write});
    end
    check("pc_held_in_reset", inst_addr, 32'h0);

    inst = ADDI5; rs_data = 32'h0; rt_data = 32'h0;
    tick();
    rst_b = 1'b0;
    check("walk_pc0", inst_addr, 32'h0);
    tick(); check("walk_pc4", inst_addr, 32'h4);
    tick(); check("walk_pc8", inst_addr, 32'h8);
    tick(); check("walk_pcC", inst_addr, 32'hC);
    tick(); check("walk_pc10", inst_addr, 32'h10);

    // beq taken, jr back, beq not taken
    inst = 32'h1022_0003; rs_data = 32'd7; rt_data = 32'd7;
    #1; check("beq_zero", {31'h0, zero}, 32'h1);
    tick(); check("beq_taken_pc", inst_addr, 32'h20);
    inst = 32'h0020_0008; rs_data = 32'h10;
    #1; check("jr_no_write", {31'h0, reg_write}, 32'h0);
    tick(); check("jr_pc", inst_addr, 32'h10);
    inst = 32'h1022_0003; rs_data = 32'd7; rt_data = 32'd8;
    tick(); check("beq_not_taken_pc", inst_addr, 32'h14);

    // j, bne taken, backward beq
    inst = 32'h0800_0040;
    tick(); check("j_pc", inst_addr, 32'h100);
    inst = 32'h1422_0003; rs_data = 32'd7; rt_data = 32'd8;
    tick(); check("bne_taken_pc", inst_addr, 32'h110);
    inst = 32'h1022_FFFF; rs_data = 32'd3; rt_data = 32'd3;
    tick(); check("beq_back_pc", inst_addr, 32'h110);

    // PC wrap
    inst = 32'h0020_0008; rs_data = 32'hFFFF_FFFC;
    tick(); check("jr_top_pc", inst_addr, 32'hFFFF_FFFC);
    inst = ADDI5; rs_data = 32'h0;
    tick(); check("pc_wrap", inst_addr, 32'h0);

    // Reset beats a pending jump
    inst = 32'h0020_0008; rs_data = 32'h40; rst_b = 1'b1;
    tick(); check("reset_priority", inst_addr, 32'h0);

    // syscall at PC 8
    inst = ADDI5; rs_data = 32'h0; rst_b = 1'b0;
    tick(); tick();
    check("sys_pc", inst_addr, 32'h8);
    inst = 32'h0000_000C;
    #1;
    check("sys_cycle_rw", {31'h0, reg_write}, 32'h0);
    check("sys_cycle_mw", {31'h0, mem_write_en}, 32'h0);
    tick();
    check("sys_halted", {31'h0, halted}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      inst = (k % 2 == 0) ? ADDI5 : 32'hAC22_0004;
      #1;
      check("halt_rw", {31'h0, reg_write}, 32'h0);
      check("halt_mw", {31'h0, mem_write_en}, 32'h0);
      tick();
      check("halt_pc", inst_addr, 32'h8);
      check("halt_sticky", {31'h0, halted}, 32'h1);
    end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("unhalt", {31'h0, halted}, 32'h0);
    check("unhalt_pc", inst_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
